// File: rtl/cache_pkg.sv
// Shared types and constants for the SDRAM burst arbiter: FSM encoding,
// requester count and default block geometry.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    STROBE = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam int NUM_REQ         = 2;
  localparam int BLOCKSIZE_W_DEF = 5;
  localparam int ADDR_W_DEF      = 16;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_burst_arbiter_if.sv
// Requester/SDRAM-side signal bundle of the burst arbiter.
interface sdram_burst_arbiter_if
  import cache_pkg::*;
#(
  parameter int BLOCKSIZE_W = BLOCKSIZE_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
);
  // Handshake: req[i] is a level held by requester i until it sees done[i];
  // gnt[i] is high for the whole burst, done[i] pulses once in the last
  // cycle, and req[i] must be low from the following edge on.
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            wr;
  logic [ADDR_W-1:0]             base_addr0;
  logic [ADDR_W-1:0]             base_addr1;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [BLOCKSIZE_W-1:0]        offset;
  logic [ADDR_W+BLOCKSIZE_W-1:0] sdram_addr;
  logic                          wr_rd_sdram;
  logic                          memstrb;
  logic                          busy;

  modport master (
    output req, wr, base_addr0, base_addr1,
    input  gnt, done, offset, sdram_addr, wr_rd_sdram, memstrb, busy
  );

  modport slave (
    input  req, wr, base_addr0, base_addr1,
    output gnt, done, offset, sdram_addr, wr_rd_sdram, memstrb, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] win_o
);
  always_comb begin
    win_o = req_i;
    if (req_i == 2'b11) begin
      win_o = last_i ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/sdram_burst_arbiter.sv
// Grants the SDRAM port to one of two block requesters and sequences the
// whole burst: offset counter, one strobe per word, direction and done.
module sdram_burst_arbiter
  import cache_pkg::*;
#(
  parameter int BLOCKSIZE_W = BLOCKSIZE_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdram_burst_arbiter_if.slave  bus,
  output state_t                dbg_state_o
);

  localparam logic [BLOCKSIZE_W-1:0] OFF_LAST = {BLOCKSIZE_W{1'b1}};
  localparam logic [BLOCKSIZE_W-1:0] OFF_ONE  = {{(BLOCKSIZE_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   id_q, id_d;
  logic                   last_q, last_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [BLOCKSIZE_W-1:0] offset_q, offset_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   memstrb_q, memstrb_d;
  logic                   busy_q, busy_d;
  logic                   wr_rd_q, wr_rd_d;
  logic [NUM_REQ-1:0]     win;

  rr_arb2 u_arb (
    .req_i  (bus.req),
    .last_i (last_q),
    .win_o  (win)
  );

  // Output registers are loaded with the values of the state being entered,
  // so every output is a flop that lines up with dbg_state_o.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    last_d    = last_q;
    base_d    = base_q;
    offset_d  = offset_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    memstrb_d = 1'b0;
    busy_d    = busy_q;
    wr_rd_d   = wr_rd_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          id_d     = win[1];
          base_d   = win[1] ? bus.base_addr1 : bus.base_addr0;
          wr_rd_d  = bus.wr[win[1]];
          offset_d = '0;
          gnt_d    = win;
          busy_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        memstrb_d = 1'b1;
        state_d   = STROBE;
      end
      STROBE: begin
        if (offset_q == OFF_LAST) begin
          done_d  = id_to_onehot(id_q);
          state_d = DONE;
        end else begin
          offset_d = offset_q + OFF_ONE;
          state_d  = SETUP;
        end
      end
      DONE: begin
        last_d   = id_q;
        gnt_d    = '0;
        busy_d   = 1'b0;
        wr_rd_d  = 1'b0;
        offset_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      base_q    <= '0;
      offset_q  <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      memstrb_q <= 1'b0;
      busy_q    <= 1'b0;
      wr_rd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      last_q    <= last_d;
      base_q    <= base_d;
      offset_q  <= offset_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      memstrb_q <= memstrb_d;
      busy_q    <= busy_d;
      wr_rd_q   <= wr_rd_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.offset      = offset_q;
  assign bus.sdram_addr  = {base_q, offset_q};
  assign bus.wr_rd_sdram = wr_rd_q;
  assign bus.memstrb     = memstrb_q;
  assign bus.busy        = busy_q;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/sdram_burst_arbiter.md
# sdram_burst_arbiter

- Shares the single SDRAM port between two block-transfer requesters, e.g. two cache FSMs (I-side and D-side), or a cache FSM and a DMA.
- Round-robin arbitration picks one requester, which then owns the port for one whole block burst.
- The block sequences the burst itself: word offset counter, one `memstrb` pulse per word, `wr_rd_sdram` direction, and completion pulse.
- Sits between the cache controllers and the SDRAM model. It replaces the per-FSM offset counter and strobe logic.

## Interface
Parameters:
- BLOCKSIZE_W, 5, offset width; block = 2^BLOCKSIZE_W words
- ADDR_W, 16, block base address width (tag+index)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  per-requester burst request, level, held until its `done`
- wr  in  2  per-requester direction; 1 = writeback to SDRAM, 0 = fill from SDRAM
- base_addr0  in  ADDR_W  block base address, requester 0
- base_addr1  in  ADDR_W  block base address, requester 1
- gnt  out  2  one-hot grant, high for the entire burst including DONE
- done  out  2  one-cycle pulse to the granted requester, burst complete
- offset  out  BLOCKSIZE_W  current word offset, drives cache SRAM offset
- sdram_addr  out  ADDR_W+BLOCKSIZE_W  {latched base, offset}
- wr_rd_sdram  out  1  latched `wr` of granted requester; 0 outside a burst
- memstrb  out  1  word strobe, high one cycle per word
- busy  out  1  high in any state except IDLE

## Operation
- All outputs are registered. Reset value of every output is 0.
- Internal last-served pointer `last` resets to 1, so requester 0 wins the first tie.
- States: IDLE, SETUP, STROBE, DONE.
- **IDLE**
  - If any `req` bit is high, select a winner:
    - only one requesting: that one;
    - both requesting: the one != `last`.
  - Latch the winner's id, `wr` and base address. Load offset=0. Go to SETUP.
  - `gnt`, `busy` and `wr_rd_sdram` become valid from SETUP onward.
- **SETUP**: `memstrb`=0 → STROBE.
- **STROBE**: `memstrb`=1.
  - offset < 2^BLOCKSIZE_W−1: offset+1 → SETUP.
  - offset == all-ones: → DONE.
- **DONE**:
  - `done[id]`=1 for this cycle only; `gnt` still held; offset stays all-ones.
  - Set `last` = id → IDLE.
  - Leaving DONE clears `gnt`, `wr_rd_sdram`, offset and `busy`.
- Offset counter is unsigned BLOCKSIZE_W bits and never wraps within a burst; the terminal test is all-ones.
- `req` is ignored outside IDLE:
  - a requester dropping `req` mid-burst does not abort the burst;
  - a new `req` from the other requester waits.
- Simultaneous rise of both `req` in IDLE: resolved by `last`, with no lost request. The loser stays pending and is granted in the IDLE that follows DONE.
- A requester must drop `req` at the clock edge after it sees `done`. If it still holds `req` in IDLE, it is treated as a new request and arbitrated normally.
- Base address and direction are latched at grant. Later changes on `base_addr*`/`wr` have no effect on the running burst.
- `rst_n` assertion mid-burst:
  - immediate return to IDLE with all outputs 0 and `last`=1;
  - no `done` pulse is issued.

## Timing
- Cycle 0: `req` seen high in IDLE.
- Cycle 1: `gnt`/`busy`/`wr_rd_sdram` high; SETUP, offset 0.
- Word k strobe: cycle 2+2k (`memstrb`=1, `offset`=k). This gives 2^BLOCKSIZE_W strobes, one every other cycle.
- DONE/`done` at cycle 2^(BLOCKSIZE_W+1)+1; IDLE at +2.
  - Default (BLOCKSIZE_W=5): last strobe cycle 64, `done` cycle 65, IDLE cycle 66.
- Back-to-back arbitration: the next grant appears 2 cycles after DONE (IDLE decide, then SETUP). This gives a 1-cycle IDLE bubble between bursts.
- `sdram_addr` is stable for the full SETUP+STROBE pair of each word.

## Structure
- Shared package `cache_pkg`:
  - state localparams (IDLE=2'b00, SETUP=2'b01, STROBE=2'b10, DONE=2'b11);
  - requester-count constant NUM_REQ=2;
  - BLOCKSIZE_W default.
- One sub-module: `rr_arb2`, combinational 2-way round-robin pick from `req` and `last`, returning a one-hot winner.
- FSM, counter and latches live in the top module.

## Test plan
- Single write: req=2'b01, wr=2'b01, base_addr0=16'h0A5C → gnt=01 at cycle 1; 32 `memstrb` pulses with sdram_addr 21'h14B80..21'h14B9F; wr_rd_sdram=1; done=01 at cycle 65.
- Single fill on requester 1: req=2'b10, wr=0 → gnt=10, wr_rd_sdram=0 throughout, 32 strobes, done=10 at cycle 65.
- Simultaneous req=2'b11 after reset → requester 0 granted first. Requester 1 is granted 2 cycles after done[0], i.e. gnt=10 at cycle 67. A third tie afterwards goes to requester 0.
- Mid-burst changes: drop req[0] and change base_addr0 at cycle 10 → burst still completes with the original address, all 32 strobes, done at cycle 65.
- Reset at cycle 20 of a burst → all outputs 0 asynchronously, no done. After release, req=2'b11 grants requester 0.
- BLOCKSIZE_W=2 build: 4 strobes at cycles 2,4,6,8; done at cycle 9; offset never exceeds 3.
